id_stage: RTL

- Instruction Decode stage, directly downstream of the instruction fetch stage.
- Latches the fetched instruction each cycle and owns the 8 x 32-bit architectural register file.
- Resolves conditional branches back to fetch, serves the fetch stage's BR register read port, and drives a registered ID/EX pipeline bundle to execute.

---
 rtl/id_pkg.sv | 52 +++++
 rtl/id_stage_if.sv | 33 +++
 rtl/id_regfile.sv | 36 +++
 rtl/id_stage.sv | 87 ++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, field positions,
// condition codes and the branch-condition evaluator.
package id_pkg;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_AW   = 3;

    localparam logic [6:0]  OP_B      = 7'b1100000;
    localparam logic [6:0]  OP_BCOND  = 7'b1100001;
    localparam logic [6:0]  OP_BR     = 7'b1100010;
    localparam logic [6:0]  OP_NOP    = 7'b1100100;
    localparam logic [31:0] NOP_INSTR = 32'hC8000000;

    localparam int unsigned OPC_LSB = 25;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned RS1_LSB = 19;
    localparam int unsigned RS2_LSB = 16;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [2:0] {
        COND_EQ = 3'b000,
        COND_NE = 3'b001,
        COND_LT = 3'b010,
        COND_GE = 3'b011,
        COND_CS = 3'b100,
        COND_CC = 3'b101,
        COND_MI = 3'b110,
        COND_AL = 3'b111
    } cond_e;

    // nzcv is packed {N,Z,C,V}
    function automatic logic cond_true(input logic [2:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic res;
        {n, z, c, v} = nzcv;
        res = 1'b0;
        case (cond_e'(cond))
            COND_EQ: res = z;
            COND_NE: res = !z;
            COND_LT: res = (n != v);
            COND_GE: res = (n == v);
            COND_CS: res = c;
            COND_CC: res = !c;
            COND_MI: res = n;
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Signal bundle between the ID stage and its neighbours (fetch, execute, writeback).
interface id_stage_if;
    import id_pkg::*;

    logic [31:0]       instruction_in;
    logic [3:0]        flags_nzcv;
    logic              write_enable;
    logic [REG_AW-1:0] write_addr;
    logic [DATA_W-1:0] write_value;
    logic [REG_AW-1:0] br_addr;
    logic [DATA_W-1:0] br_value;
    logic              b_cond;
    logic [15:0]       b_rel_addr;
    logic              ex_valid;
    logic [6:0]        ex_opcode;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_op_a;
    logic [DATA_W-1:0] ex_op_b;
    logic [DATA_W-1:0] ex_imm;

    modport master (
        output instruction_in, flags_nzcv, write_enable, write_addr, write_value, br_addr,
        input  br_value, b_cond, b_rel_addr,
        input  ex_valid, ex_opcode, ex_rd, ex_op_a, ex_op_b, ex_imm
    );

    modport slave (
        input  instruction_in, flags_nzcv, write_enable, write_addr, write_value, br_addr,
        output br_value, b_cond, b_rel_addr,
        output ex_valid, ex_opcode, ex_rd, ex_op_a, ex_op_b, ex_imm
    );

endinterface

// File: rtl/id_regfile.sv
// 8x32 register file: one write port, two write-through read ports for
// operands, one raw read port for fetch's BR lookup.
module id_regfile
    import id_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [REG_AW-1:0] ra_a,
    input  logic [REG_AW-1:0] ra_b,
    input  logic [REG_AW-1:0] ra_raw,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic [DATA_W-1:0] rd_raw
);

    logic [DATA_W-1:0] rf [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else if (we) begin
            rf[wa] <= wd;
        end
    end

    assign rd_a   = (we && (wa == ra_a)) ? wd : rf[ra_a];
    assign rd_b   = (we && (wa == ra_b)) ? wd : rf[ra_b];
    // Fetch applies its own bypass, so this port deliberately sees the old value.
    assign rd_raw = rf[ra_raw];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: latches the fetched word, resolves B.cond,
// reads operands and drives the registered ID/EX bundle.
module id_stage
    import id_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    id_stage_if.slave  bus
);

    logic [31:0]       id_instr;
    logic [6:0]        opcode;
    logic [2:0]        cond;
    logic [REG_AW-1:0] rs1, rs2;
    logic [15:0]       imm16;
    logic              b_cond;
    logic              consumed;
    logic [DATA_W-1:0] op_a, op_b;

    logic              ex_valid_q;
    logic [6:0]        ex_opcode_q;
    logic [REG_AW-1:0] ex_rd_q;
    logic [DATA_W-1:0] ex_op_a_q, ex_op_b_q, ex_imm_q;

    assign opcode = id_instr[OPC_LSB +: 7];
    assign cond   = id_instr[RD_LSB  +: 3];
    assign rs1    = id_instr[RS1_LSB +: REG_AW];
    assign rs2    = id_instr[RS2_LSB +: REG_AW];
    assign imm16  = id_instr[IMM_LSB +: 16];

    // A taken branch replaces the wrong-path word with NOP, so it never evaluates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_instr <= NOP_INSTR;
        end else begin
            id_instr <= b_cond ? NOP_INSTR : bus.instruction_in;
        end
    end

    always_comb begin
        b_cond   = (opcode == OP_BCOND) && cond_true(cond, bus.flags_nzcv);
        consumed = (opcode == OP_NOP) || (opcode == OP_B) ||
                   (opcode == OP_BR)  || (opcode == OP_BCOND);
    end

    id_regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (bus.write_enable),
        .wa     (bus.write_addr),
        .wd     (bus.write_value),
        .ra_a   (rs1),
        .ra_b   (rs2),
        .ra_raw (bus.br_addr),
        .rd_a   (op_a),
        .rd_b   (op_b),
        .rd_raw (bus.br_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_opcode_q <= '0;
            ex_rd_q     <= '0;
            ex_op_a_q   <= '0;
            ex_op_b_q   <= '0;
            ex_imm_q    <= '0;
        end else begin
            ex_valid_q  <= !consumed;
            ex_opcode_q <= opcode;
            ex_rd_q     <= id_instr[RD_LSB +: REG_AW];
            ex_op_a_q   <= op_a;
            ex_op_b_q   <= op_b;
            ex_imm_q    <= {{(DATA_W-16){imm16[15]}}, imm16};
        end
    end

    assign bus.b_cond     = b_cond;
    assign bus.b_rel_addr = b_cond ? imm16 : '0;
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_opcode  = ex_opcode_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_op_a    = ex_op_a_q;
    assign bus.ex_op_b    = ex_op_b_q;
    assign bus.ex_imm     = ex_imm_q;

endmodule
